// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the load/store stage and its store buffer.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned WORD_W          = 32;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;
  localparam logic [WORD_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  // Counter only has to reach TIMEOUT_CYC-1 before the abort fires.
  function automatic int unsigned cnt_width(input int unsigned cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

  localparam int unsigned TO_CNT_W_DEF = cnt_width(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/store_buffer.sv
// One-entry posted store buffer; only built when STORE_BUFFER_EN is defined.
`ifdef STORE_BUFFER_EN
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WORD_W-1:0] data_o
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule
`endif

// File: rtl/data_mem_ctrl.sv
// Load/store stage driving a req/ack memory bus and stalling the core until done.
// Optional STORE_BUFFER_EN adds a one-entry posted store buffer.
module data_mem_ctrl
  import mips_mem_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter logic [WORD_W-1:0] ERR_DATA    = ERR_DATA_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       Addr,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              Stall,
  output logic              Misaligned,
  output logic              BusErr,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [WORD_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [WORD_W-1:0] bus_rdata
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              stall_c;
  logic              access_c;
  logic              aligned_c;
  logic              posted_c;
  logic [ADDR_W-1:0] word_addr_c;

  assign access_c    = MemRead | MemWrite;
  assign aligned_c   = (Addr[1:0] == 2'b00);
  assign word_addr_c = {Addr[ADDR_W-1:2], 2'b00};

`ifdef STORE_BUFFER_EN
  logic              sb_load, sb_clear, sb_valid;
  logic [ADDR_W-1:0] sb_addr;
  logic [WORD_W-1:0] sb_data;

  store_buffer #(.ADDR_W(ADDR_W)) u_store_buffer (
    .clk     (CLK),
    .rst     (reset),
    .load_i  (sb_load),
    .clear_i (sb_clear),
    .addr_i  (word_addr_c),
    .data_i  (WriteData),
    .valid_o (sb_valid),
    .addr_o  (sb_addr),
    .data_o  (sb_data)
  );

  assign posted_c  = sb_valid;
  assign bus_we    = we_q | sb_valid;
  assign bus_addr  = sb_valid ? sb_addr : addr_q;
  assign bus_wdata = sb_valid ? sb_data : wdata_q;
`else
  assign posted_c  = 1'b0;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
`endif

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    stall_c = 1'b0;
`ifdef STORE_BUFFER_EN
    sb_load  = 1'b0;
    sb_clear = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (access_c && aligned_c) begin
          state_d = REQ;
          req_d   = 1'b1;
          cnt_d   = '0;
`ifdef STORE_BUFFER_EN
          if (!MemRead) begin
            sb_load = 1'b1;
          end else begin
            we_d    = 1'b0;
            addr_d  = word_addr_c;
            stall_c = 1'b1;
          end
`else
          we_d    = !MemRead;
          addr_d  = word_addr_c;
          wdata_d = WriteData;
          stall_c = 1'b1;
`endif
        end
      end
      REQ: begin
        // A background drain only holds the core if it tries another access.
        stall_c = posted_c ? access_c : 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (bus_ack || (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          cnt_d   = '0;
          err_d   = !bus_ack;
          state_d = posted_c ? IDLE : DONE;
          if (!we_q && !posted_c) begin
            rdata_d = bus_ack ? bus_rdata : ERR_DATA;
          end
`ifdef STORE_BUFFER_EN
          sb_clear = 1'b1;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Stall      = stall_c & ~reset;
  assign Misaligned = access_c & ~aligned_c;
  assign BusErr     = err_q;
  assign bus_req    = req_q;
  assign ReadData   = rdata_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: retire and bus monitors check queued expectations.
module tb_data_mem_ctrl;

  localparam int TO = 16;
`ifdef STORE_BUFFER_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  typedef struct {
    string       name;
    int          stall;
    logic [31:0] rdata;
    bit          mis;
    bit          berr;
  } ret_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          cycles;
  } bus_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall, Misaligned, BusErr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 CLK = ~CLK;

  data_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .CLK(CLK), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .Misaligned(Misaligned), .BusErr(BusErr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  int vec = 0;
  int miscmp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Memory model and ack responder
  logic [31:0] mem [logic [31:0]];
  int ack_q[$];
  bit rbusy = 0, racc, force_ack = 0;
  int rwait, rcnt;

  always @(negedge CLK) begin
    racc = 0;
    if (bus_req && !reset) begin
      if (!rbusy) begin
        rbusy = 1;
        rcnt  = 0;
        rwait = (ack_q.size() > 0) ? ack_q.pop_front() : -1;
      end
      racc = (rcnt == rwait);
      if (racc) begin
        if (bus_we) mem[bus_addr] = bus_wdata;
        else bus_rdata = mem.exists(bus_addr) ? mem[bus_addr] : 32'h0;
      end
      rcnt++;
    end else begin
      rbusy = 0;
    end
    bus_ack = racc | force_ack;
  end

  // Bus monitor
  bus_t bus_q[$];
  bus_t bcur;
  bit btrk = 0, bstable;
  int bcnt;
  logic [31:0] b_a0, b_w0;
  logic b_we0;

  always @(negedge CLK) begin
    if (bus_req) begin
      if (!btrk) begin
        btrk = 1; bcnt = 0; bstable = 1;
        b_a0 = bus_addr; b_w0 = bus_wdata; b_we0 = bus_we;
        if (bus_q.size() == 0) begin
          bcur.cycles = -1;
          chk("unexpected_bus_req", 32'(bus_req), 32'h0);
        end else begin
          bcur = bus_q.pop_front();
          chk("bus_we", 32'(bus_we), 32'(bcur.we));
          chk("bus_addr", bus_addr, bcur.addr);
          if (bcur.we) chk("bus_wdata", bus_wdata, bcur.wdata);
        end
      end else if (bus_addr !== b_a0 || bus_wdata !== b_w0 || bus_we !== b_we0) begin
        bstable = 0;
      end
      bcnt++;
    end else if (btrk) begin
      btrk = 0;
      chk("bus_stable", 32'(bstable), 32'h1);
      if (bcur.cycles >= 0) chk("bus_req_cycles", 32'(bcnt), 32'(bcur.cycles));
    end
  end

  // Retire monitor: an access with Stall low retires at the next edge
  ret_t ret_q[$];
  ret_t rcur;
  int scnt = 0;

  always @(negedge CLK) begin
    if (reset) begin
      scnt = 0;
    end else if (MemRead || MemWrite) begin
      if (Stall) begin
        scnt++;
      end else begin
        if (ret_q.size() == 0) begin
          vec++; miscmp++;
          $display("FAIL unexpected_retire: got addr %h, want no retire", Addr);
        end else begin
          rcur = ret_q.pop_front();
          chk({rcur.name, "_stall_cycles"}, 32'(scnt), 32'(rcur.stall));
          chk({rcur.name, "_ReadData"}, ReadData, rcur.rdata);
          chk({rcur.name, "_Misaligned"}, 32'(Misaligned), 32'(rcur.mis));
          chk({rcur.name, "_BusErr"}, 32'(BusErr), 32'(rcur.berr));
        end
        scnt = 0;
      end
    end
`ifndef STORE_BUFFER_EN
    if (!reset && BusErr && !((MemRead || MemWrite) && !Stall)) begin
      vec++; miscmp++;
      $display("FAIL stray_BusErr: got 1, want 0 outside retire");
    end
`endif
  end

  task automatic wait_bus_idle();
    int n = 0;
    while (bus_req && n < 64) begin
      @(negedge CLK);
      n++;
    end
    if (bus_req) begin
      vec++; miscmp++;
      $display("FAIL bus_idle_timeout: got bus_req=1, want 0 within 64 cycles");
    end
    @(posedge CLK); #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the instruction retires.
  task automatic issue(input string nm, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input int wt, input int stall_e,
                       input logic [31:0] rd_e, input bit mis_e, input bit berr_e,
                       input bit wait_idle);
    bit done = 0;
    if (wait_idle) wait_bus_idle();
    ret_q.push_back('{nm, stall_e, rd_e, mis_e, berr_e});
    if (!mis_e) begin
      ack_q.push_back(wt);
      bus_q.push_back('{!rd && wr, {a[31:2], 2'b00}, wd, (wt < 0) ? TO : wt + 1});
    end
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge CLK);
      if (!Stall) done = 1;
    end
    if (!done) begin
      vec++; miscmp++;
      $display("FAIL %s_retire_timeout: got Stall=1, want release within 64 cycles", nm);
    end
    @(posedge CLK); #1;
    MemRead = 0; MemWrite = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    mem[32'h40] = 32'h1234_5678;
    mem[32'h48] = 32'h0BAD_0048;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ReadData", ReadData, 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_we", 32'(bus_we), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wdata", bus_wdata, 32'h0);
    chk("rst_BusErr", 32'(BusErr), 32'h0);
    chk("rst_Stall", 32'(Stall), 32'h0);
    reset = 0;
    @(posedge CLK); #1;

    issue("lw_40",     1, 0, 32'h40, 32'h0,         0, 2,                  32'h1234_5678, 0, 0, 1);
    issue("sw_44",     0, 1, 32'h44, 32'hCAFE_0001, 4, SB ? 0 : 6,         32'h1234_5678, 0, 0, 1);
    issue("lw_44",     1, 0, 32'h44, 32'h0,         2, 4,                  32'hCAFE_0001, 0, 0, 1);
    issue("lw_42_mis", 1, 0, 32'h42, 32'h0,         0, 0,                  32'hCAFE_0001, 1, 0, 1);
    issue("sw_4a_mis", 0, 1, 32'h4A, 32'hFFFF_0000, 0, 0,                  32'hCAFE_0001, 1, 0, 1);
    issue("lw_48",     1, 0, 32'h48, 32'h0,         0, 2,                  32'h0BAD_0048, 0, 0, 1);
    issue("lw_4c_to",  1, 0, 32'h4C, 32'h0,        -1, 1 + TO,             32'hDEAD_BEEF, 0, 1, 1);
    issue("rw_40",     1, 1, 32'h40, 32'h5555_5555, 1, 3,                  32'h1234_5678, 0, 0, 1);
    issue("sw_54_to",  0, 1, 32'h54, 32'h7777_7777,-1, SB ? 0 : 1 + TO,    32'h1234_5678, 0, !SB, 1);

    // Reset in the middle of REQ, then a late ack in IDLE
    wait_bus_idle();
    ack_q.push_back(-1);
    bus_q.push_back('{1'b0, 32'h40, 32'h0, -1});
    MemRead = 1; Addr = 32'h40;
    repeat (4) @(posedge CLK);
    #2 reset = 1;
    #1;
    chk("rstmid_bus_req", 32'(bus_req), 32'h0);
    chk("rstmid_Stall", 32'(Stall), 32'h0);
    chk("rstmid_ReadData", ReadData, 32'h0);
    MemRead = 0;
    @(posedge CLK); #1;
    reset = 0;
    force_ack = 1;
    @(posedge CLK); #1;
    force_ack = 0;
    @(negedge CLK);
    chk("late_ack_bus_req", 32'(bus_req), 32'h0);
    chk("late_ack_ReadData", ReadData, 32'h0);
    chk("late_ack_BusErr", 32'(BusErr), 32'h0);
    @(posedge CLK); #1;

    issue("lw_40_rst", 1, 0, 32'h40, 32'h0, 0, 2, 32'h1234_5678, 0, 0, 1);

`ifdef STORE_BUFFER_EN
    issue("sw_50_post", 0, 1, 32'h50, 32'h5A5A_0050, 3, 0, 32'h1234_5678, 0, 0, 1);
    issue("lw_50",      1, 0, 32'h50, 32'h0,         0, 6, 32'h5A5A_0050, 0, 0, 0);
`endif

    wait_bus_idle();
    repeat (4) @(posedge CLK);
    chk("ret_q_drained", 32'(ret_q.size()), 32'h0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Load/store stage that sits directly downstream of the datapath unit. It consumes the datapath's ALUResult (as the address) and WriteData, plus the control unit's MemRead/MemWrite, and returns ReadData to the datapath's rData_MUX. It drives a variable-latency, single-port req/ack memory bus and raises Stall so the single-cycle core holds PC and suppresses RegWrite until the access completes.

Parameters:
ADDR_W, 32, width of bus_addr; takes Addr[ADDR_W-1:0]
TIMEOUT_CYC, 16, REQ cycles without bus_ack before an access is aborted (range 1..255)
ERR_DATA, 32'hDEADBEEF, ReadData value returned on a timed-out load

Ports:
CLK  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
MemRead  in  1  current instruction is a load (lw)
MemWrite  in  1  current instruction is a store (sw)
Addr  in  32  byte address from the datapath ALUResult
WriteData  in  32  store data from the datapath WriteData
ReadData  out  32  registered load data to the datapath
Stall  out  1  hold PC, inhibit RegWrite while high
Misaligned  out  1  Addr[1:0]!=0 on an access; combinational
BusErr  out  1  one-cycle pulse when an access times out
bus_req  out  1  bus request
bus_we  out  1  1 = write, 0 = read
bus_addr  out  ADDR_W  word-aligned address
bus_wdata  out  32  write data
bus_ack  in  1  one-cycle completion strobe from memory
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset (async, active-high): state=IDLE; ReadData=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, BusErr=0, timeout counter=0. Stall deasserts immediately.
- access = MemRead|MemWrite. MemRead&MemWrite together is treated as a read.
- IDLE: if access & aligned: latch Addr/WriteData/we into bus_* registers, go to REQ. Stall=1 combinationally during this cycle. If access & misaligned: Misaligned=1, Stall=0, no bus cycle, store dropped, ReadData unchanged.
- REQ: bus_req=1. bus_addr/bus_we/bus_wdata stay stable until ack. Stall=1. Counter increments each cycle.
  - On bus_ack: for a read, ReadData<=bus_rdata. Go to DONE. bus_req drops at the next edge.
  - If the counter reaches TIMEOUT_CYC without ack: drop bus_req, BusErr pulses for 1 cycle, a read sets ReadData<=ERR_DATA, go to DONE.
  - bus_ack outside REQ is ignored.
- DONE: Stall=0 for exactly one cycle, so the instruction retires at this edge. Next state is IDLE. An access seen in DONE is not restarted.
- Minimum latency: an instruction is held 3 cycles (IDLE-detect, REQ with immediate ack, DONE). Each additional wait cycle adds 1.
- Reset during REQ aborts the transfer. No ack is expected afterwards, and a late ack is ignored.

Optional Feature:
STORE_BUFFER_EN.
- Defined: a one-entry posted store buffer is added.
  - A store in IDLE with the buffer empty is captured into the buffer with Stall=0, and the instruction retires the same cycle.
  - The buffer drains through REQ in the background.
  - Any access while the buffer is occupied stalls until the drain completes; loads therefore always observe the buffered store.
  - A timed-out drain pulses BusErr and discards the entry.
- Undefined: every store stalls exactly as specified above.

Decomposition:
- Package mips_mem_pkg holds:
  - state enum {IDLE, REQ, DONE}
  - WORD_W=32
  - default ERR_DATA
  - the timeout counter width, derived from TIMEOUT_CYC.
- One sub-module, store_buffer: holds valid/addr/data, load/clear handshake, and is instantiated only under STORE_BUFFER_EN.

Test Plan:
- lw, Addr=32'h40, memory acks in the 1st REQ cycle with 32'h1234_5678 -> Stall high 2 cycles, ReadData=32'h1234_5678 in DONE, bus_we=0.
- sw, Addr=32'h44, WriteData=32'hCAFE_0001, ack after 4 wait cycles -> bus_addr/bus_wdata stable through REQ, Stall high 6 cycles, then low 1.
- lw, Addr=32'h42 -> Misaligned=1, Stall=0, bus_req never asserted, ReadData unchanged.
- lw with no ack, TIMEOUT_CYC=16 -> bus_req high 16 cycles, BusErr 1-cycle pulse, ReadData=32'hDEADBEEF, Stall released.
- reset asserted in the middle of REQ -> bus_req and Stall drop asynchronously, state IDLE, a late ack is ignored.
- STORE_BUFFER_EN: sw 32'h50 then lw 32'h50 on the next cycle -> sw retires with Stall=0, lw stalls until the drain acks, then returns the stored data.
